// File: rtl/shift_ramp_envelope_if.sv
// Sample stream bundle for the shift-ramp envelope: ROM sample in, scaled sample out.
interface shift_ramp_envelope_if #(
  parameter int unsigned WL = 16
);
  logic signed [WL-1:0] data_in;
  logic                 data_valid;
  logic signed [WL-1:0] data_out;
  logic                 data_out_valid;

  modport master (output data_in, output data_valid, input data_out, input data_out_valid);
  modport slave  (input data_in, input data_valid, output data_out, output data_out_valid);
endinterface

// File: rtl/shift_ramp_envelope.sv
// Amplitude ramp envelope: scales signed samples by 2^-(WL-level) while an FSM ramps level up/hold/down.
// Optional macro SHIFT_RAMP_ROUND_EN selects round-half-up instead of truncating shift.
module shift_ramp_envelope #(
  parameter  int unsigned WL    = 16,
  parameter  int unsigned DWELL = 1,
  localparam int unsigned LVL_W = $clog2(WL + 1)
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     EN,
  input  logic                     STEP_EN,
  shift_ramp_envelope_if.slave     bus,
  output logic [LVL_W-1:0]         level,
  output logic [1:0]               state,
  output logic                     ramp_done,
  output logic                     z_flg
);

  localparam int unsigned DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_UP   = 2'd1,
    S_HOLD = 2'd2,
    S_DOWN = 2'd3
  } state_t;

  state_t               r_state;
  logic [LVL_W-1:0]     r_level;
  logic [DW_W-1:0]      r_dwell;
  logic                 r_ramp_done;
  logic                 r_z_flg;
  logic signed [WL-1:0] r_data_out;
  logic                 r_data_out_valid;

  logic                 w_dwell_last;
  logic [LVL_W-1:0]     w_shamt;
  logic signed [WL-1:0] w_scaled;

  assign w_dwell_last = (r_dwell == DW_W'(DWELL - 1));
  assign w_shamt      = LVL_W'(WL) - r_level;

`ifdef SHIFT_RAMP_ROUND_EN
  // One extra bit of headroom so the half-LSB bias can never overflow.
  logic signed [WL:0] w_ext;
  logic signed [WL:0] w_bias;
  logic signed [WL:0] w_sum;
  logic signed [WL:0] w_shifted;

  assign w_ext     = {bus.data_in[WL-1], bus.data_in};
  assign w_bias    = (w_shamt == '0) ? '0 : ((WL+1)'(1) << (w_shamt - LVL_W'(1)));
  assign w_sum     = w_ext + w_bias;
  assign w_shifted = w_sum >>> w_shamt;
  assign w_scaled  = w_shifted[WL-1:0];
`else
  assign w_scaled  = bus.data_in >>> w_shamt;
`endif

  // Level-0 forces zero so negative samples never leak out as -1.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_data_out       <= '0;
      r_data_out_valid <= 1'b0;
    end else begin
      r_data_out_valid <= bus.data_valid;
      if (bus.data_valid) begin
        r_data_out <= (r_level == '0) ? '0 : w_scaled;
      end
    end
  end

  // Ramp FSM; a state change always takes priority over a level step.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= S_IDLE;
      r_level     <= '0;
      r_dwell     <= '0;
      r_ramp_done <= 1'b0;
      r_z_flg     <= 1'b0;
    end else begin
      r_z_flg <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_level     <= '0;
          r_dwell     <= '0;
          r_ramp_done <= 1'b0;
          if (EN) begin
            r_state <= S_UP;
          end
        end
        S_UP: begin
          if (!EN) begin
            r_state <= S_DOWN;
            r_dwell <= '0;
          end else if (r_level == LVL_W'(WL)) begin
            r_state     <= S_HOLD;
            r_dwell     <= '0;
            r_ramp_done <= 1'b1;
          end else if (STEP_EN) begin
            if (w_dwell_last) begin
              r_level <= r_level + LVL_W'(1);
              r_dwell <= '0;
              if (r_level == LVL_W'(WL - 1)) begin
                r_state     <= S_HOLD;
                r_ramp_done <= 1'b1;
              end
            end else begin
              r_dwell <= r_dwell + DW_W'(1);
            end
          end
        end
        S_HOLD: begin
          r_level <= LVL_W'(WL);
          if (!EN) begin
            r_state     <= S_DOWN;
            r_dwell     <= '0;
            r_ramp_done <= 1'b0;
          end
        end
        S_DOWN: begin
          if (EN) begin
            r_state <= S_UP;
            r_dwell <= '0;
          end else if (r_level == '0) begin
            r_state <= S_IDLE;
            r_dwell <= '0;
            r_z_flg <= 1'b1;
          end else if (STEP_EN) begin
            if (w_dwell_last) begin
              r_level <= r_level - LVL_W'(1);
              r_dwell <= '0;
              if (r_level == LVL_W'(1)) begin
                r_state <= S_IDLE;
                r_z_flg <= 1'b1;
              end
            end else begin
              r_dwell <= r_dwell + DW_W'(1);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.data_out       = r_data_out;
  assign bus.data_out_valid = r_data_out_valid;
  assign level              = r_level;
  assign state              = r_state;
  assign ramp_done          = r_ramp_done;
  assign z_flg              = r_z_flg;

endmodule

// File: tb/tb_shift_ramp_envelope.sv
// Scoreboard bench for shift_ramp_envelope: one DWELL=1 instance for datapath/ramp, one DWELL=4 for dwell/re-entry.
module tb_shift_ramp_envelope;

  localparam int unsigned WL = 16;

`ifdef SHIFT_RAMP_ROUND_EN
  localparam logic [15:0] E_4000_L1 = 16'h0001;
  localparam logic [15:0] E_7FFF_L1 = 16'h0001;
`else
  localparam logic [15:0] E_4000_L1 = 16'h0000;
  localparam logic [15:0] E_7FFF_L1 = 16'h0000;
`endif

  logic       CLK;
  logic       RST_N;
  logic       en1, step1, en4, step4;
  logic [4:0] level1, level4;
  logic [1:0] state1, state4;
  logic       done1, done4, z1, z4;

  int n_chk;
  int n_err;
  logic [15:0] sb_q[$];

  shift_ramp_envelope_if #(.WL(WL)) bus1 ();
  shift_ramp_envelope_if #(.WL(WL)) bus4 ();

  shift_ramp_envelope #(.WL(WL), .DWELL(1)) u_d1 (
    .CLK(CLK), .RST_N(RST_N), .EN(en1), .STEP_EN(step1), .bus(bus1.slave),
    .level(level1), .state(state1), .ramp_done(done1), .z_flg(z1)
  );

  shift_ramp_envelope #(.WL(WL), .DWELL(4)) u_d4 (
    .CLK(CLK), .RST_N(RST_N), .EN(en4), .STEP_EN(step4), .bus(bus4.slave),
    .level(level4), .state(state4), .ramp_done(done4), .z_flg(z4)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic [15:0] e);
    bus1.data_valid = v;
    bus1.data_in    = d;
    if (v) sb_q.push_back(e);
  endtask

  // Scoreboard monitor: one expected sample per valid output cycle.
  initial begin
    forever begin
      @(negedge CLK);
      if (bus1.data_out_valid === 1'b1) begin
        n_chk++;
        if (sb_q.size() == 0) begin
          n_err++;
          $display("FAIL data_out unexpected: got %0h expected none", bus1.data_out);
        end else begin
          logic [15:0] e;
          e = sb_q.pop_front();
          if (bus1.data_out !== e) begin
            n_err++;
            $display("FAIL data_out: got %0h expected %0h", bus1.data_out, e);
          end
        end
      end
    end
  end

  initial begin
    n_chk = 0;
    n_err = 0;
    RST_N = 1'b0;
    en1 = 1'b0; step1 = 1'b0; en4 = 1'b0; step4 = 1'b0;
    bus1.data_in = '0; bus1.data_valid = 1'b0;
    bus4.data_in = '0; bus4.data_valid = 1'b0;
    repeat (2) cyc();
    chk("rst_state", 32'(state1), 32'd0);
    chk("rst_level", 32'(level1), 32'd0);
    chk("rst_dout", {16'd0, bus1.data_out}, 32'd0);
    chk("rst_dvalid", 32'(bus1.data_out_valid), 32'd0);
    chk("rst_done", 32'(done1), 32'd0);
    chk("rst_z", 32'(z1), 32'd0);
    RST_N = 1'b1;
    cyc();

    // Ramp up with DWELL=1
    en1 = 1'b1; step1 = 1'b1;
    cyc();
    chk("up_enter_state", 32'(state1), 32'd1);
    chk("up_enter_level", 32'(level1), 32'd0);
    for (int l = 0; l < 16; l++) begin
      if (l == 0)       drive(1'b1, 16'h8000, 16'h0000);
      else if (l == 1)  drive(1'b1, 16'h4000, E_4000_L1);
      else if (l == 15) drive(1'b1, 16'h4000, 16'h2000);
      else              drive(1'b0, 16'h0000, 16'h0000);
      cyc();
      chk("up_level", 32'(level1), 32'(l + 1));
      chk("up_state", 32'(state1), (l == 15) ? 32'd2 : 32'd1);
      chk("up_done", 32'(done1), (l == 15) ? 32'd1 : 32'd0);
    end
    drive(1'b1, 16'h4000, 16'h4000);
    cyc();
    chk("hold_level", 32'(level1), 32'd16);
    drive(1'b1, 16'h8000, 16'h8000);
    cyc();
    drive(1'b0, 16'h0000, 16'h0000);

    // Ramp down
    en1 = 1'b0;
    cyc();
    chk("down_enter_state", 32'(state1), 32'd3);
    chk("down_enter_level", 32'(level1), 32'd16);
    chk("down_enter_done", 32'(done1), 32'd0);
    for (int l = 16; l > 1; l--) begin
      cyc();
      chk("down_level", 32'(level1), 32'(l - 1));
      chk("down_state", 32'(state1), 32'd3);
      chk("down_z", 32'(z1), 32'd0);
    end
    step1 = 1'b0;
    drive(1'b1, 16'h8000, 16'hFFFF);
    cyc();
    chk("down_pause_level", 32'(level1), 32'd1);
    step1 = 1'b1;
    drive(1'b1, 16'h7FFF, E_7FFF_L1);
    cyc();
    drive(1'b0, 16'h0000, 16'h0000);
    chk("zero_state", 32'(state1), 32'd0);
    chk("zero_level", 32'(level1), 32'd0);
    chk("zero_z", 32'(z1), 32'd1);
    cyc();
    chk("zero_z_pulse", 32'(z1), 32'd0);

    // EN dropped in UP before the first step
    en1 = 1'b1; step1 = 1'b0;
    cyc();
    chk("drop0_up", 32'(state1), 32'd1);
    en1 = 1'b0;
    cyc();
    chk("drop0_down", 32'(state1), 32'd3);
    chk("drop0_down_z", 32'(z1), 32'd0);
    cyc();
    chk("drop0_idle", 32'(state1), 32'd0);
    chk("drop0_z", 32'(z1), 32'd1);
    cyc();
    chk("drop0_z_pulse", 32'(z1), 32'd0);

    // DWELL=4: dwell counting, simultaneous event, re-entry
    en4 = 1'b1; step4 = 1'b1;
    cyc();
    chk("d4_up", 32'(state4), 32'd1);
    repeat (3) cyc();
    chk("d4_three", 32'(level4), 32'd0);
    step4 = 1'b0;
    repeat (2) cyc();
    chk("d4_gap", 32'(level4), 32'd0);
    step4 = 1'b1;
    cyc();
    chk("d4_fourth", 32'(level4), 32'd1);
    repeat (16) cyc();
    chk("d4_l5", 32'(level4), 32'd5);
    repeat (3) cyc();
    chk("d4_l5_hold", 32'(level4), 32'd5);
    en4 = 1'b0;
    cyc();
    chk("simul_state", 32'(state4), 32'd3);
    chk("simul_level", 32'(level4), 32'd5);
    en4 = 1'b1;
    cyc();
    chk("reup_state", 32'(state4), 32'd1);
    chk("reup_level", 32'(level4), 32'd5);
    repeat (43) cyc();
    chk("d4_l15", 32'(level4), 32'd15);
    cyc();
    chk("d4_hold_state", 32'(state4), 32'd2);
    chk("d4_hold_level", 32'(level4), 32'd16);
    chk("d4_hold_done", 32'(done4), 32'd1);
    en4 = 1'b0;
    cyc();
    chk("d4_down", 32'(state4), 32'd3);
    repeat (28) cyc();
    chk("d4_l9", 32'(level4), 32'd9);
    en4 = 1'b1;
    cyc();
    chk("reentry_state", 32'(state4), 32'd1);
    chk("reentry_level", 32'(level4), 32'd9);
    repeat (3) cyc();
    chk("reentry_three", 32'(level4), 32'd9);
    cyc();
    chk("reentry_fourth", 32'(level4), 32'd10);
    en4 = 1'b0; step4 = 1'b0;

    // Asynchronous reset mid-UP at level 7
    en1 = 1'b1; step1 = 1'b1;
    cyc();
    repeat (6) cyc();
    drive(1'b1, 16'h4000, 16'h0010);
    cyc();
    drive(1'b0, 16'h0000, 16'h0000);
    step1 = 1'b0;
    chk("pre_rst_level", 32'(level1), 32'd7);
    chk("pre_rst_dout", {16'd0, bus1.data_out}, 32'h0010);
    @(negedge CLK);
    #1;
    RST_N = 1'b0;
    #1;
    chk("arst_state", 32'(state1), 32'd0);
    chk("arst_level", 32'(level1), 32'd0);
    chk("arst_dout", {16'd0, bus1.data_out}, 32'd0);
    chk("arst_z", 32'(z1), 32'd0);
    en1 = 1'b0;
    repeat (2) cyc();
    RST_N = 1'b1;
    cyc();
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/shift_ramp_envelope.md
Name: shift_ramp_envelope

Overview:
- Parametrised successor to the right-shift amplitude ramp for the stimulation path.
- Scales signed ROM samples by 2^-(WL-level) using an arithmetic right shift.
- A 4-state FSM ramps level up on enable, holds at full scale, then ramps back down to zero instead of cutting off abruptly.
- Dwell count per level is configurable, and input/output carry valid qualifiers.

Parameters:
- WL, 16, sample word length in bits; level range is 0..WL.
- DWELL, 1, number of STEP_EN strobes per level change (>=1).
- LVL_W, $clog2(WL+1), localparam width of level.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- EN  input  1  master stimulation enable.
- STEP_EN  input  1  level step strobe, one count per cycle high.
- data_in  input  WL  signed sample from ROM.
- data_valid  input  1  data_in qualifier.
- data_out  output  WL  signed scaled sample, registered.
- data_out_valid  output  1  data_out qualifier.
- level  output  LVL_W  current ramp level.
- state  output  2  FSM state: IDLE=0, UP=1, HOLD=2, DOWN=3.
- ramp_done  output  1  high while state==HOLD.
- z_flg  output  1  one-cycle pulse when DOWN reaches level 0.

Behaviour:
- Reset (RST_N=0, async): state=IDLE, level=0, dwell counter=0, data_out=0, data_out_valid=0, ramp_done=0, z_flg=0.
- Datapath, latency 1:
  - On a cycle with data_valid=1: data_out <= (level==0) ? 0 : data_in >>> (WL-level).
  - data_out_valid <= data_valid.
  - data_out holds its value when data_valid=0.
  - Level 0 forces 0, so negative inputs never yield -1 at level 0.
  - The shift uses the level value registered before the current edge.
- Dwell counter:
  - Counts STEP_EN strobes in UP and DOWN.
  - When the count reaches DWELL-1 and STEP_EN=1, level steps and the counter clears.
  - Cleared on every state change.
  - Ignored in IDLE and HOLD.
- IDLE: level=0. EN=1 -> UP.
- UP:
  - Level increments per dwell.
  - A step that makes level==WL -> HOLD in the same edge.
  - EN=0 -> DOWN, with no step that cycle.
- HOLD: level=WL, ramp_done=1. EN=0 -> DOWN.
- DOWN:
  - Level decrements per dwell.
  - A step that makes level==0 -> IDLE, and z_flg=1 for exactly that following cycle.
  - EN=1 -> UP from the current level, counter cleared.
- Simultaneous events:
  - If EN changes on the same cycle as a qualifying STEP_EN, the state change wins and level does not step.
- Saturation: level never exceeds WL and never goes below 0.
- Mid-operation reset: immediate return to reset values, with no z_flg.
- EN dropped in UP at level 0 (before the first step): -> DOWN, then -> IDLE on the next cycle with a z_flg pulse.

Optional Feature:
- Macro: SHIFT_RAMP_ROUND_EN.
- Defined (round-half-up):
  - For shift s=WL-level in 1..WL-1, data_out = (data_in + 2^(s-1)) >>> s.
  - Computed in WL+1 bits and truncated to WL; the result always fits.
  - s=0 passes data_in unchanged; level 0 still gives 0.
- Undefined: plain truncating arithmetic shift, as above.

Test Plan:
- Reset: assert RST_N=0 mid-UP at level 7 -> level=0, state=IDLE, data_out=0, z_flg=0, all asynchronously, without waiting for CLK.
- Ramp up (WL=16, DWELL=1, data_in=16'sh4000, data_valid=1, STEP_EN=1 every cycle, EN=1):
  - level 1 -> data_out=0; level 15 -> 16'sh2000; level 16 -> 16'sh4000.
  - ramp_done rises after 16 strobes.
- Negative input: data_in=16'sh8000 -> level 0 gives 0, level 1 gives 16'shFFFF, level 16 gives 16'sh8000.
  - With SHIFT_RAMP_ROUND_EN, level 1 gives 16'shFFFF; data_in=16'sh7FFF at level 1 gives 16'sh0001.
- Ramp down: drop EN in HOLD -> DOWN, level steps 16->0 over 16 strobes, then z_flg high for exactly 1 cycle and state=IDLE.
- Dwell and re-entry (DWELL=4):
  - Level changes only on every 4th STEP_EN.
  - Reassert EN in DOWN at level 9 -> state=UP, level stays 9, next increment after 4 further strobes.
- Simultaneous: EN falls on the same cycle as the 4th strobe at level 5 in UP -> state=DOWN, level remains 5.
